// File: rtl/adder_arbiter.sv
// Four-requester arbiter time-sharing one external 8-bit adder with a registered response.
// Define ADDER_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module adder_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*WIDTH-1:0] Op1,
    input  logic [NREQ*WIDTH-1:0] Op2,
    output logic [NREQ-1:0]       Gnt,
    output logic [WIDTH-1:0]      Add_A,
    output logic [WIDTH-1:0]      Add_B,
    input  logic [WIDTH-1:0]      Add_Sum,
    output logic                  Rsp_Valid,
    input  logic                  Rsp_Ready,
    output logic [1:0]            Rsp_Id,
    output logic [WIDTH-1:0]      Rsp_Sum,
    output logic [15:0]           Op_Count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]      state;
    logic            win_valid;
    logic [1:0]      win_idx;
    logic            arb_en;
    logic [NREQ-1:0] gnt_next;

`ifndef ADDER_ARBITER_FIXED_PRIO_EN
    logic [1:0] last;
    logic [1:0] cand;
`endif

    // Later loop iterations overwrite earlier ones, so the last hit has highest priority.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
`ifdef ADDER_ARBITER_FIXED_PRIO_EN
        for (int unsigned i = NREQ; i > 0; i--) begin
            if (Req[i-1]) begin
                win_valid = 1'b1;
                win_idx   = 2'(i - 1);
            end
        end
`else
        cand = '0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            cand = last + 2'(k);
            if (Req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
`endif
    end

    always_comb begin
        arb_en   = (state == IDLE) || ((state == RESP) && Rsp_Ready);
        gnt_next = NREQ'(1) << win_idx;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            Gnt       <= '0;
            Add_A     <= '0;
            Add_B     <= '0;
            Rsp_Valid <= 1'b0;
            Rsp_Id    <= '0;
            Rsp_Sum   <= '0;
            Op_Count  <= '0;
`ifndef ADDER_ARBITER_FIXED_PRIO_EN
            last      <= 2'd3;
`endif
        end else begin
            Gnt <= '0;
            case (state)
                IDLE: begin
                    if (win_valid) state <= ISSUE;
                end
                ISSUE: begin
                    Rsp_Sum   <= Add_Sum;
                    Rsp_Valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (Rsp_Ready) begin
                        Rsp_Valid <= 1'b0;
                        Op_Count  <= Op_Count + 16'd1;
                        state     <= win_valid ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Grant path shared by IDLE and accept-in-RESP arbitration.
            if (arb_en && win_valid) begin
                Gnt    <= gnt_next;
                Add_A  <= Op1[win_idx*WIDTH +: WIDTH];
                Add_B  <= Op2[win_idx*WIDTH +: WIDTH];
                Rsp_Id <= win_idx;
`ifndef ADDER_ARBITER_FIXED_PRIO_EN
                last   <= win_idx;
`endif
            end
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: randomized requesters, transaction-level reference model.
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [3:0]  gnt;
    logic [7:0]  add_a, add_b, add_sum;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic [15:0] op_count;

    adder_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .Clk(clk), .Reset_n(rst_n), .Req(req), .Op1(op1), .Op2(op2), .Gnt(gnt),
        .Add_A(add_a), .Add_B(add_b), .Add_Sum(add_sum), .Rsp_Valid(rsp_valid),
        .Rsp_Ready(rsp_ready), .Rsp_Id(rsp_id), .Rsp_Sum(rsp_sum), .Op_Count(op_count)
    );

    assign add_sum = add_a + add_b;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: arbitration rule applied to the request vector as a set.
    function automatic int pick(input logic [3:0] r, input int last);
`ifdef ADDER_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int off = 1; off <= 4; off++) if (r[(last + off) % 4]) return (last + off) % 4;
`endif
        return -1;
    endfunction

    typedef struct {
        logic [1:0] id;
        logic [7:0] sum;
    } txn_t;

    txn_t        sbq[$];
    int          last_m = 3;
    logic [15:0] cnt_m = '0;
    logic        prev_valid = 1'b0;
    logic [1:0]  prev_id = '0;
    logic [7:0]  prev_sum = '0;

    // Monitor: one transaction per grant, retired on the valid/ready handshake.
    always @(posedge clk) begin
        bit          accept;
        bit          opp;
        int          w;
        logic [3:0]  exp_gnt;
        logic [7:0]  a, b;
        txn_t        t;
        #1;
        if (!rst_n) begin
            sbq.delete();
            last_m     = 3;
            cnt_m      = '0;
            prev_valid = 1'b0;
        end else begin
            accept = prev_valid && rsp_ready;
            opp    = (sbq.size() == 0) || accept;
            if (accept) begin
                if (sbq.size() == 0) begin
                    check("spurious_valid", 32'(prev_valid), 32'(0));
                end else begin
                    t = sbq.pop_front();
                    check("rsp_id_accept", 32'(prev_id), 32'(t.id));
                    check("rsp_sum_accept", 32'(prev_sum), 32'(t.sum));
                    cnt_m = cnt_m + 16'd1;
                end
            end
            check("op_count", 32'(op_count), 32'(cnt_m));
            exp_gnt = '0;
            if (opp && req != 0) begin
                w       = pick(req, last_m);
                exp_gnt = 4'(1 << w);
                last_m  = w;
                a       = op1[8*w +: 8];
                b       = op2[8*w +: 8];
                t.id    = 2'(w);
                t.sum   = 8'(a + b);
                sbq.push_back(t);
                check("add_a", 32'(add_a), 32'(a));
                check("add_b", 32'(add_b), 32'(b));
            end
            check("gnt", 32'(gnt), 32'(exp_gnt));
            check("rsp_valid", 32'(rsp_valid), 32'((sbq.size() != 0) && (exp_gnt == 0)));
            if (rsp_valid && sbq.size() != 0 && exp_gnt == 0) begin
                check("rsp_id_hold", 32'(rsp_id), 32'(sbq[0].id));
                check("rsp_sum_hold", 32'(rsp_sum), 32'(sbq[0].sum));
            end
            prev_valid = rsp_valid;
            prev_id    = rsp_id;
            prev_sum   = rsp_sum;
        end
    end

    // Advance one cycle; granted requests are consumed unless held.
    task automatic step(input bit hold);
        @(negedge clk);
        if (!hold) req = req & ~gnt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_add_a", 32'(add_a), 32'(0));
        check("rst_add_b", 32'(add_b), 32'(0));
        check("rst_valid", 32'(rsp_valid), 32'(0));
        check("rst_id", 32'(rsp_id), 32'(0));
        check("rst_sum", 32'(rsp_sum), 32'(0));
        check("rst_count", 32'(op_count), 32'(0));
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Basic add: 0x12 + 0x34 from requester 0.
        op1 = 32'h0000_0012; op2 = 32'h0000_0034; rsp_ready = 1'b1; req = 4'b0001;
        repeat (4) step(1'b0);

        // Wrapping add from requester 2.
        op1[23:16] = 8'hF0; op2[23:16] = 8'h20; req = 4'b0100;
        repeat (4) step(1'b0);

        // All requesters held high from reset: rotating grant order.
        do_reset();
        op1 = $urandom; op2 = $urandom; req = 4'b1111;
        repeat (11) step(1'b1);
        req = '0;
        repeat (3) step(1'b0);

        // Backpressure: requester 1 waits while the response is held.
        rsp_ready = 1'b0; req = 4'b0011;
        repeat (8) step(1'b0);
        rsp_ready = 1'b1;
        repeat (5) step(1'b0);

        // Asynchronous reset while a response is held.
        rsp_ready = 1'b0; req = 4'b1000;
        repeat (3) step(1'b0);
        do_reset();
        req = 4'b1111; rsp_ready = 1'b1;
        repeat (3) step(1'b0);
        req = '0;
        repeat (3) step(1'b0);

        // Randomized traffic with withdrawals and backpressure.
        for (int c = 0; c < 3000; c++) begin
            step(1'b0);
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(3) == 0) begin
                    op1[8*i +: 8] = 8'($urandom);
                    op2[8*i +: 8] = 8'($urandom);
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(31) == 0) begin
                    req[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
        end

        // Drain, preload the counter near its limit, then cross the wrap.
        req = '0; rsp_ready = 1'b1;
        repeat (4) step(1'b0);
        #1 force dut.Op_Count = 16'hFFFE;
        #1 release dut.Op_Count;
        cnt_m = 16'hFFFE;
        op1 = 32'h0000_0001; op2 = 32'h0000_0002; req = 4'b0001;
        repeat (4) step(1'b0);
        check("count_ffff", 32'(op_count), 32'h0000_FFFF);
        req = 4'b0001;
        repeat (4) step(1'b0);
        check("count_wrap", 32'(op_count), 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/sum width; only 8 is supported.
REQ-002 The block SHALL have parameter NREQ, default 4, requester count; only 4 is supported.
REQ-003 Port Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port Req  input  4  per-requester request; held high until granted.
REQ-006 Port Op1  input  32  requester i first operand at bits [8i+7:8i].
REQ-007 Port Op2  input  32  requester i second operand at bits [8i+7:8i].
REQ-008 Port Gnt  output  4  one-hot, one-cycle grant pulse; operands are sampled on the edge that raises it.
REQ-009 Port Add_A  output  8  registered first operand driven to the shared 8-bit adder.
REQ-010 Port Add_B  output  8  registered second operand driven to the shared 8-bit adder.
REQ-011 Port Add_Sum  input  8  combinational sum returned from the shared adder.
REQ-012 Port Rsp_Valid  output  1  result valid; held until accepted.
REQ-013 Port Rsp_Ready  input  1  consumer accepts the result when high with Rsp_Valid.
REQ-014 Port Rsp_Id  output  2  index of the requester owning the result.
REQ-015 Port Rsp_Sum  output  8  registered sum, modulo 256.
REQ-016 Port Op_Count  output  16  count of completed (accepted) operations.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-018 In IDLE with Req != 0: pick the winner, load Add_A/Add_B from its Op1/Op2 slices, pulse Gnt[winner], record Rsp_Id and go to ISSUE.
REQ-019 In IDLE with Req == 0: remain in IDLE with Gnt=0.
REQ-020 In ISSUE: capture Add_Sum into Rsp_Sum, set Rsp_Valid=1 and go to RESP; this always takes exactly one cycle.
REQ-021 In RESP with Rsp_Ready=0: hold Rsp_Valid, Rsp_Sum and Rsp_Id stable.
REQ-022 In RESP with Rsp_Ready=1: clear Rsp_Valid, increment Op_Count and arbitrate in the same cycle; if Req != 0, grant as in REQ-018 and go to ISSUE, otherwise go to IDLE.
REQ-023 Latency: Req rising in IDLE at edge n gives Gnt at edge n+1 and Rsp_Valid at edge n+2; back-to-back throughput is one result per 2 cycles with Rsp_Ready tied high.
REQ-024 Arbitration (default) SHALL be round-robin: search starts at Last+1 mod 4, where Last is the most recent winner; Last updates on every grant.
REQ-025 Gnt SHALL be zero-or-one-hot and SHALL be asserted only in the cycle after an arbitration decision.
REQ-026 Requests arriving while in ISSUE or RESP (without Rsp_Ready) SHALL wait; they are not dropped.
REQ-027 Sum overflow SHALL wrap modulo 256 with no carry output.
REQ-028 Op_Count SHALL wrap from 0xFFFF to 0x0000.
REQ-029 Deasserting Req[i] before grant SHALL withdraw the request with no side effect.

Reset
REQ-030 Reset_n low SHALL immediately force state IDLE, Gnt=0, Add_A=0, Add_B=0, Rsp_Valid=0, Rsp_Id=0, Rsp_Sum=0, Op_Count=0 and Last=3, so requester 0 wins first.
REQ-031 Reset mid-operation SHALL discard any in-flight result; Op_Count is not incremented.

Configuration
REQ-032 With macro ADDER_ARBITER_FIXED_PRIO_EN defined, arbitration SHALL be fixed-priority (lowest index wins) and Last is unused.
REQ-033 Without ADDER_ARBITER_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-024.

Verification
REQ-034 Scenario: reset, then Req=0001, Op1[7:0]=0x12, Op2[7:0]=0x34, Rsp_Ready=1 -> Gnt=0001 at edge 1; Rsp_Valid=1, Rsp_Id=0, Rsp_Sum=0x46 at edge 2; Op_Count=1.
REQ-035 Scenario: requester 2 with Op1=0xF0, Op2=0x20 -> Rsp_Sum=0x10 (wrap), Rsp_Id=2.
REQ-036 Scenario: Req=1111 held, Rsp_Ready=1 -> grant order 0,1,2,3,0 at 2-cycle spacing; with ADDER_ARBITER_FIXED_PRIO_EN, grants are always to 0.
REQ-037 Scenario: Rsp_Ready=0 for 5 cycles while Req=0010 -> Rsp_Valid, Rsp_Sum and Rsp_Id stay stable with no new Gnt; Rsp_Ready=1 -> Gnt=0010 in the same cycle.
REQ-038 Scenario: Reset_n pulsed low during RESP -> all outputs are 0 asynchronously; the next grant goes to requester 0.
REQ-039 Scenario: Op_Count preloaded to 0xFFFF via 65535 operations, then one more accepted -> Op_Count=0x0000.
